// File: rtl/vga_sram_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_sram_writer_pkg
// Description : Shared definitions for the VGA SRAM write path. This file holds
//               the FSM state encoding, the default timing values and a
//               ceiling-log2 helper used to size counters and pointers.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_sram_writer_pkg;

    // Write-cycle phases
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Default SRAM write timing, in clk cycles
    localparam int c_DEF_SETUP_CYCLES = 1;
    localparam int c_DEF_PULSE_CYCLES = 2;
    localparam int c_DEF_HOLD_CYCLES  = 1;

    // Ceiling log2; returns 0 for values of 0 or 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_write_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_write_fifo
// Description : Synchronous request FIFO. Pointers carry one extra bit so the
//               count distinguishes full from empty without extra state.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_write_fifo
    import vga_sram_writer_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [clog2(DEPTH):0]    count_o
);
    localparam int c_PTR_W = clog2(DEPTH);

    logic [c_PTR_W:0]   wr_ptr_q;
    logic [c_PTR_W:0]   rd_ptr_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count_o == (c_PTR_W + 1)'(DEPTH));
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q[c_PTR_W-1:0]];

    // Storage array; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[c_PTR_W-1:0]] <= wdata_i;
        end
    end

    // Read/write pointer advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_sram_writer.sv
`default_nettype none
// ============================================================================
// Module      : vga_sram_writer
// Description : Buffers (address, data) write requests and retires them to an
//               asynchronous SRAM with programmable setup/pulse/hold timing.
//               Raises a sticky done once the source is finished and drained.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sram_writer
    import vga_sram_writer_pkg::*;
#(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = c_DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = c_DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = c_DEF_HOLD_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 src_done,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [DATA_BITS-1:0] sram_data_out,
    output logic                 sram_data_oe,
    output logic                 sram_ce_n,
    output logic                 sram_we_n,
    output logic                 sram_oe_n,
    output logic                 done
);
    localparam int c_MAX_SP     = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int c_MAX_CYCLES = (c_MAX_SP > HOLD_CYCLES) ? c_MAX_SP : HOLD_CYCLES;
    localparam int c_CNT_W      = (clog2(c_MAX_CYCLES + 1) < 1) ? 1 : clog2(c_MAX_CYCLES + 1);
    localparam int c_ENTRY_W    = ADDR_BITS + DATA_BITS;
    localparam int c_PTR_W      = clog2(FIFO_DEPTH);

    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [c_PTR_W:0]       w_fifo_count;
    logic [c_ENTRY_W-1:0]   w_head;
    logic                   w_push;
    logic                   w_pop;

    state_e                 state_q, state_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   oe_q, oe_d;
    logic                   ce_n_q, ce_n_d;
    logic                   we_n_q, we_n_d;
    logic                   src_seen_q, src_seen_d;
    logic                   done_q, done_d;

    assign wr_ready = !w_fifo_full;
    assign w_push   = wr_valid && wr_ready;

    sram_write_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i ({wr_addr, wr_data}),
        .rdata_o (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // Next-state, pin values and FIFO pop for the setup/pulse/hold sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        oe_d       = oe_q;
        ce_n_d     = ce_n_q;
        w_pop      = 1'b0;
        src_seen_d = src_seen_q | src_done;
        done_d     = done_q | (src_seen_q && (w_fifo_count == '0) &&
                               (state_q == ST_IDLE) && !w_push);

        unique case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    addr_d  = w_head[DATA_BITS +: ADDR_BITS];
                    data_d  = w_head[DATA_BITS-1:0];
                    oe_d    = 1'b1;
                    ce_n_d  = 1'b0;
                    cnt_d   = c_CNT_W'(SETUP_CYCLES - 1);
                    state_d = ST_SETUP;
                end else begin
                    oe_d    = 1'b0;
                    ce_n_d  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = c_CNT_W'(PULSE_CYCLES - 1);
                    state_d = ST_PULSE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = c_CNT_W'(HOLD_CYCLES - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - 1'b1;
                end else if (!w_fifo_empty) begin
                    // Back-to-back: reload on the final hold edge, keep ce/oe asserted
                    w_pop   = 1'b1;
                    addr_d  = w_head[DATA_BITS +: ADDR_BITS];
                    data_d  = w_head[DATA_BITS-1:0];
                    cnt_d   = c_CNT_W'(SETUP_CYCLES - 1);
                    state_d = ST_SETUP;
                end else begin
                    oe_d    = 1'b0;
                    ce_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // we_n is low exactly while the registered state is PULSE
        we_n_d = (state_d != ST_PULSE);
    end

    // State and registered SRAM pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            oe_q       <= 1'b0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            src_seen_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            oe_q       <= oe_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
            src_seen_q <= src_seen_d;
            done_q     <= done_d;
        end
    end

    assign sram_addr     = addr_q;
    assign sram_data_out = data_q;
    assign sram_data_oe  = oe_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_oe_n     = 1'b1;
    assign done          = done_q;

endmodule
`default_nettype wire
